// File: rtl/vector_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_checker_if : record stream and mismatch-FIFO readout bus      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vector_checker_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1
);
  logic                      s_valid;
  logic                      s_ready;
  logic [IN_W-1:0]           s_in;
  logic [OUT_W-1:0]          s_y;
  logic [OUT_W-1:0]          s_yexp;
  logic                      err_rd;
  logic                      err_valid;
  logic [IN_W+2*OUT_W-1:0]   err_data;

  modport master (
    output s_valid, s_in, s_y, s_yexp, err_rd,
    input  s_ready, err_valid, err_data
  );

  modport slave (
    input  s_valid, s_in, s_y, s_yexp, err_rd,
    output s_ready, err_valid, err_data
  );
endinterface
`default_nettype wire

// File: rtl/vector_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_checker : compares {in, y, yexp} records, counts vectors and  |
// | mismatches, buffers the first mismatches in a small FWFT FIFO.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vector_checker #(
  parameter int IN_W      = 3,
  parameter int OUT_W     = 1,
  parameter int NVEC      = 8,
  parameter int LOG_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  vector_checker_if.slave   bus,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int                   DEPTH     = 1 << LOG_DEPTH;
  localparam int                   DW        = IN_W + 2 * OUT_W;
  localparam logic [CNT_W-1:0]     C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]     C_LAST    = CNT_W'(NVEC - 1);
  localparam logic [LOG_DEPTH:0]   C_FULL    = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_enter_run;
  logic                  w_accept;
  logic                  w_mismatch;
  logic                  w_hit;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DW-1:0]         w_rec;

  logic [DW-1:0]         r_mem [DEPTH];
  logic [LOG_DEPTH-1:0]  r_wptr;
  logic [LOG_DEPTH-1:0]  r_rptr;
  logic [LOG_DEPTH:0]    r_occ;
  logic [DW-1:0]         r_last;
  logic [CNT_W-1:0]      r_vec;
  logic [CNT_W-1:0]      r_err;
  logic                  r_ovf;

  assign w_accept   = bus.s_valid & (r_state == S_RUN);
  assign w_mismatch = (bus.s_y != bus.s_yexp);
  assign w_hit      = w_accept & w_mismatch;
  assign w_rec      = {bus.s_in, bus.s_y, bus.s_yexp};

  // A full FIFO still takes the record when the head is popped on the same edge.
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == C_FULL);
  assign w_pop   = bus.err_rd & ~w_empty;
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (w_accept && (r_vec == C_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vec <= '0;
      r_err <= '0;
      r_ovf <= 1'b0;
    end else if (w_enter_run) begin
      r_vec <= '0;
      r_err <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (r_vec != C_CNT_MAX) begin
        r_vec <= r_vec + CNT_W'(1);
      end
      if (w_mismatch && (r_err != C_CNT_MAX)) begin
        r_err <= r_err + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  // r_last keeps the most recently popped word so err_data holds when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LOG_DEPTH'(1);
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + LOG_DEPTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (LOG_DEPTH + 1)'(1);
        2'b01:   r_occ <= r_occ - (LOG_DEPTH + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.s_ready   = (r_state == S_RUN);
  assign bus.err_valid = ~w_empty;
  assign bus.err_data  = w_empty ? r_last : r_mem[r_rptr];
  assign vec_count     = r_vec;
  assign err_count     = r_err;
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vector_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vector_checker : directed and random checks against a queue model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vector_checker;
  localparam int IN_W = 3, OUT_W = 1, NVEC = 8, LOG_DEPTH = 2, CNT_W = 32;
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int DW = IN_W + 2 * OUT_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [CNT_W-1:0] vec_count, err_count;
  logic busy, done, overflow;
  int n_tests = 0;
  int n_fail = 0;

  vector_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  vector_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .NVEC(NVEC), .LOG_DEPTH(LOG_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .vec_count(vec_count), .err_count(err_count), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: run phase, counts, and the mismatch FIFO as a bounded queue.
  int            m_phase;   // 0 idle, 1 running, 2 finished
  int            m_vec, m_err;
  bit            m_ovf;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last;

  task automatic model_reset();
    m_phase = 0; m_vec = 0; m_err = 0; m_ovf = 0; m_q.delete(); m_last = '0;
  endtask

  task automatic tick();
    bit acc;
    acc = bus.s_valid && (m_phase == 1);
    if (bus.err_rd && m_q.size() > 0) m_last = m_q.pop_front();
    if (m_phase != 1 && start) begin
      m_phase = 1; m_vec = 0; m_err = 0; m_ovf = 0;
    end else if (acc) begin
      m_vec++;
      if (bus.s_y !== bus.s_yexp) begin
        m_err++;
        if (m_q.size() < DEPTH) m_q.push_back({bus.s_in, bus.s_y, bus.s_yexp});
        else m_ovf = 1;
      end
      if (m_vec == NVEC) m_phase = 2;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input logic [IN_W-1:0] a, input logic y, input logic ye,
                       input bit rd, input bit st);
    bus.s_valid = v; bus.s_in = a; bus.s_y = y; bus.s_yexp = ye; bus.err_rd = rd; start = st;
    tick();
  endtask

  function automatic logic ref_y(input logic [2:0] a);
    return (~a[1] & ~a[0]) | (a[2] & ~a[1]);
  endfunction

  task automatic test_reset();
    bus.s_valid = 0; bus.s_in = '0; bus.s_y = '0; bus.s_yexp = '0; bus.err_rd = 0; start = 0;
    model_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.s_ready); end
    n_tests++; if ({busy, done, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); end
    n_tests++; if (vec_count !== '0 || err_count !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", vec_count, err_count); end
    n_tests++; if (bus.err_valid !== 1'b0 || bus.err_data !== '0) begin n_fail++; $display("FAIL reset_fifo: got %b/%b want 0/0", bus.err_valid, bus.err_data); end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clean_run();
    drive(0, 0, 0, 0, 0, 1);
    n_tests++; if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL clean_busy: got %b/%b want 1/1", busy, bus.s_ready); end
    for (int i = 0; i < NVEC; i++) begin
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL clean_early_done: got %b want 0 at rec %0d", done, i); end
      drive(1, 3'(i), ref_y(3'(i)), ref_y(3'(i)), 0, 0);
    end
    n_tests++; if (done !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL clean_done: got done=%b ready=%b want 1/0", done, bus.s_ready); end
    n_tests++; if (vec_count !== 8 || err_count !== 0) begin n_fail++; $display("FAIL clean_counts: got %0d/%0d want 8/0", vec_count, err_count); end
    n_tests++; if (bus.err_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clean_fifo: got ev=%b ovf=%b want 0/0", bus.err_valid, overflow); end
  endtask

  task automatic test_single_mismatch();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) begin
      if (i == 4) drive(1, 3'd4, 1'b0, 1'b1, 0, 0);
      else drive(1, 3'(i), ref_y(3'(i)), ref_y(3'(i)), 0, 0);
    end
    n_tests++; if (err_count !== 1) begin n_fail++; $display("FAIL single_errcnt: got %0d want 1", err_count); end
    n_tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 5'b100_0_1) begin n_fail++; $display("FAIL single_head: got %b/%b want 1/10001", bus.err_valid, bus.err_data); end
    drive(0, 0, 0, 0, 1, 0);
    n_tests++; if (bus.err_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b want 0", bus.err_valid); end
    n_tests++; if (bus.err_data !== 5'b100_0_1) begin n_fail++; $display("FAIL single_hold: got %b want 10001", bus.err_data); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_q [4];
    int pops;
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 3'(i), 1'b0, 1'b1, 0, 0);
    drive(1, 3'd6, ref_y(3'd6), ref_y(3'd6), 0, 0);
    drive(1, 3'd7, ref_y(3'd7), ref_y(3'd7), 0, 0);
    n_tests++; if (err_count !== 6 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_counts: got err=%0d ovf=%b want 6/1", err_count, overflow); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== {3'(i), 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_pop%0d: got %b/%b want 1/%b", i, bus.err_valid, bus.err_data, {3'(i), 2'b01}); end
      drive(0, 0, 0, 0, 1, 0);
    end
    n_tests++; if (bus.err_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", bus.err_valid); end
    // Full FIFO with a simultaneous pop and mismatching accept.
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 3'(i), 1'b0, 1'b1, 0, 0);
    drive(1, 3'd7, 1'b1, 1'b0, 1, 0);
    n_tests++; if (overflow !== 1'b0 || err_count !== 5) begin n_fail++; $display("FAIL full_rw: got ovf=%b err=%0d want 0/5", overflow, err_count); end
    exp_q = '{5'b001_0_1, 5'b010_0_1, 5'b011_0_1, 5'b111_1_0};
    pops = 0;
    while (bus.err_valid === 1'b1 && pops < 4) begin
      n_tests++; if (bus.err_data !== exp_q[pops]) begin n_fail++; $display("FAIL full_rw_data%0d: got %b want %b", pops, bus.err_data, exp_q[pops]); end
      drive(0, 0, 0, 0, 1, 0);
      pops++;
    end
    n_tests++; if (pops !== 4 || bus.err_valid !== 1'b0) begin n_fail++; $display("FAIL full_rw_occ: got %0d entries ev=%b want 4/0", pops, bus.err_valid); end
    for (int i = 0; i < 3; i++) drive(1, 3'd0, ref_y(3'd0), ref_y(3'd0), 0, 0);
    n_tests++; if (done !== 1'b1 || vec_count !== 8) begin n_fail++; $display("FAIL full_rw_done: got %b/%0d want 1/8", done, vec_count); end
  endtask

  task automatic test_gaps_oversend();
    int offered, k;
    bit v;
    logic [2:0] a;
    drive(0, 0, 0, 0, 0, 1);
    offered = 0; k = 0;
    while (offered < 10 && k < 100) begin
      v = (k % 4 == 0) || (k % 4 == 3);
      n_tests++; if (bus.s_ready !== (m_phase == 1)) begin n_fail++; $display("FAIL gap_ready%0d: got %b want %b", k, bus.s_ready, m_phase == 1); end
      a = 3'($urandom_range(0, 7));
      if (v) offered++;
      drive(v, a, ref_y(a), ref_y(a), 0, 0);
      k++;
    end
    n_tests++; if (vec_count !== 8 || done !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL gap_count: got %0d done=%b rdy=%b want 8/1/0", vec_count, done, bus.s_ready); end
    drive(1, 3'd0, 1'b0, 1'b1, 0, 0);
    n_tests++; if (vec_count !== 8 || err_count !== 0) begin n_fail++; $display("FAIL gap_after_done: got %0d/%0d want 8/0", vec_count, err_count); end
  endtask

  task automatic test_reset_midrun();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 3'd0, 1'b0, 1'b1, 0, 0);
    drive(1, 3'd1, ref_y(3'd1), ref_y(3'd1), 0, 0);
    drive(1, 3'd2, ref_y(3'd2), ref_y(3'd2), 0, 0);
    bus.s_valid = 0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if ({busy, done, overflow, bus.s_ready, bus.err_valid} !== 5'b0) begin n_fail++; $display("FAIL midrst_flags: got %b want 00000", {busy, done, overflow, bus.s_ready, bus.err_valid}); end
    n_tests++; if (vec_count !== '0 || err_count !== '0 || bus.err_data !== '0) begin n_fail++; $display("FAIL midrst_vals: got %0d/%0d/%b want 0/0/0", vec_count, err_count, bus.err_data); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_start: got busy=%b want 0", busy); end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got %b/%b want 0/0", busy, done); end
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) drive(1, 3'(i), ref_y(3'(i)), ref_y(3'(i)), 0, 0);
    n_tests++; if (vec_count !== 8 || done !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun: got %0d/%b want 8/1", vec_count, done); end
  endtask

  task automatic test_restart();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NVEC; i++) begin
      if (i == 1 || i == 6) drive(1, 3'(i), ~ref_y(3'(i)), ref_y(3'(i)), 0, 0);
      else drive(1, 3'(i), ref_y(3'(i)), ref_y(3'(i)), 0, 0);
    end
    n_tests++; if (done !== 1'b1 || err_count !== 2) begin n_fail++; $display("FAIL restart_first: got %b/%0d want 1/2", done, err_count); end
    drive(0, 0, 0, 0, 0, 1);
    n_tests++; if (vec_count !== 0 || err_count !== 0 || overflow !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_clear: got %0d/%0d/%b/%b want 0/0/0/1", vec_count, err_count, overflow, busy); end
    n_tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 5'b001_1_0) begin n_fail++; $display("FAIL restart_fifo: got %b/%b want 1/00110", bus.err_valid, bus.err_data); end
    for (int i = 0; i < NVEC; i++) drive(1, 3'(i), ref_y(3'(i)), ref_y(3'(i)), 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    n_tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 5'b110_1_0) begin n_fail++; $display("FAIL restart_second: got %b/%b want 1/11010", bus.err_valid, bus.err_data); end
    drive(0, 0, 0, 0, 1, 0);
    n_tests++; if (bus.err_valid !== 1'b0) begin n_fail++; $display("FAIL restart_drain: got %b want 0", bus.err_valid); end
  endtask

  task automatic test_random();
    logic [2:0] a;
    logic y, ye;
    logic [DW-1:0] exp_d;
    for (int k = 0; k < 400; k++) begin
      a  = 3'($urandom_range(0, 7));
      y  = 1'($urandom_range(0, 1));
      ye = ($urandom_range(0, 2) == 0) ? ~y : y;
      drive($urandom_range(0, 1) == 1, a, y, ye, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
      exp_d = (m_q.size() > 0) ? m_q[0] : m_last;
      n_tests++; if (vec_count !== CNT_W'(m_vec) || err_count !== CNT_W'(m_err)) begin n_fail++; $display("FAIL rnd_counts@%0d: got %0d/%0d want %0d/%0d", k, vec_count, err_count, m_vec, m_err); end
      n_tests++; if (busy !== (m_phase == 1) || done !== (m_phase == 2) || bus.s_ready !== (m_phase == 1)) begin n_fail++; $display("FAIL rnd_state@%0d: got b=%b d=%b r=%b want phase %0d", k, busy, done, bus.s_ready, m_phase); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", k, overflow, m_ovf); end
      n_tests++; if (bus.err_valid !== (m_q.size() > 0) || bus.err_data !== exp_d) begin n_fail++; $display("FAIL rnd_fifo@%0d: got %b/%b want %b/%b", k, bus.err_valid, bus.err_data, m_q.size() > 0, exp_d); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_single_mismatch();
    test_overflow();
    test_gaps_oversend();
    test_reset_midrun();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
